re_mapper_multisym: RTL and testbench
=====================================

// Module: re_mapper_multisym
// PURPOSE
//  Parametrised PUSCH resource-element mapper, successor to the single-DMRS-symbol mapper.
//  Maps a slot span Sym_Start..Sym_End into the grid RAM.
//  - Any symbol flagged in Dmrs_Sym_Map is a DMRS symbol: comb-2 DMRS, other REs zero.
//  - All other symbols carry the transform-precoded (FFT) data stream.
//  Sits between the DMRS generator / DFT block and the grid RAM that feeds the IFFT.
//  Valid/ready on both inputs; 1 RE per cycle.
// PARAMETERS
//  DATA_W     18    width of FFT samples and of the RE output
//  DMRS_W     9     width of DMRS samples (sign-extended to DATA_W)
//  DMRS_SHIFT 0     left shift applied to DMRS after sign-extension (amplitude alignment)
//  ADDR_W     11    grid subcarrier address width
//  NSC_TOT    1200  subcarriers in the grid; mapping limit
//  NSYM       14    symbols per slot (width of Dmrs_Sym_Map)
// PORTS
//  CLK_RE        in   1         clock
//  RST_RE        in   1         synchronous, active-high reset
//  Start         in   1         pulse: latch config and begin the slot
//  N_sc          in   ADDR_W    first allocated subcarrier
//  N_rb          in   7         allocated RBs
//  Sym_Start     in   4         first symbol of the allocation
//  Sym_End       in   4         last symbol of the allocation
//  Dmrs_Sym_Map  in   NSYM      bit s=1: symbol s is DMRS
//  Dmrs_Comb     in   1         DMRS on REs with k[0]==Dmrs_Comb (k relative to N_sc)
//  Dmrs_I/Q      in   DMRS_W    DMRS sample
//  Dmrs_Valid    in   1         DMRS sample present
//  Dmrs_Ready    out  1         DMRS sample consumed this cycle when also valid
//  FFT_I/Q       in   DATA_W    data sample
//  FFT_Valid     in   1         data sample present
//  FFT_Ready     out  1         data sample consumed this cycle when also valid
//  RE_Real/Imj   out  DATA_W    RE written to grid
//  RE_Valid_Out  out  1         grid write strobe
//  Wr_addr       out  ADDR_W    grid subcarrier address, = N_sc + k
//  Wr_sym        out  4         grid symbol index
//  Sym_Done      out  1         pulse with the last RE of each symbol
//  RE_Done       out  1         pulse with the last RE of the slot
//  Busy          out  1         high from accepted Start until RE_Done
//  Cfg_Err       out  1         set on a rejected config; cleared by next Start
// BEHAVIOUR
//  Reset
//   - All outputs 0; state IDLE; counters 0.
//   - Reset mid-slot aborts the slot immediately: no Sym_Done or RE_Done is issued.
//  States
//   - IDLE: on Start, latch all config.
//     - Error if N_rb==0, Sym_Start>Sym_End, Sym_End>=NSYM, or N_sc+12*N_rb>NSC_TOT (12-bit compare).
//     - On error: Cfg_Err=1 next cycle, stay IDLE.
//     - Otherwise: Cfg_Err=0, Busy=1, sym=Sym_Start, k=0, go to MAP.
//   - MAP: position k in 0..12*N_rb-1 of symbol sym.
//     - DMRS symbol, k[0]==Dmrs_Comb:
//       - Dmrs_Ready=1; advance only when Dmrs_Valid.
//       - Output = sign-extended DMRS << DMRS_SHIFT, on both I and Q.
//     - DMRS symbol, other k:
//       - No input is consumed; write 0+j0; always advance.
//     - Data symbol:
//       - FFT_Ready=1; advance only when FFT_Valid.
//     - Ready outputs are combinational from state and k; all other outputs are registered.
//     - Latency: an advance in cycle n produces RE_Valid_Out in cycle n+1.
//     - Any cycle without an advance gives RE_Valid_Out=0 next cycle; k does not move.
//     - At k==12*N_rb-1 with an advance:
//       - Sym_Done pulses with that RE.
//       - If sym==Sym_End: RE_Done pulses with that RE, then IDLE.
//       - Otherwise: sym+1, k=0, with no bubble cycle.
//  Other rules
//   - Start while Busy is ignored; config is stable for the whole slot.
//   - A stream valid that is asserted in the wrong symbol type is left pending, never dropped.
//   - Throughput: 12*N_rb cycles per symbol when inputs never stall.
//   - Wr_addr never wraps: the config check guarantees N_sc+k < NSC_TOT.
//   - Only one of Dmrs_Ready and FFT_Ready can be high in any cycle.
// STRUCTURE
//  Shared package re_map_pkg
//   - NSC_TOT, NSYM, RE_PER_RB=12
//   - State encoding typedef
//   - Function dmrs_ext(): sign-extend and shift
//  Sub-module re_cfg_check
//   - Purely combinational config validation.
//   - Outputs the error flag and sc_count=12*N_rb.
//  Top level
//   - FSM, k/sym counters, output register stage.
// TESTING
//  1. N_sc=0, N_rb=1, Sym 2..3, map bit2, comb0, both streams always valid:
//     - addr 0..11 at sym2: even=DMRS, odd=0.
//     - addr 0..11 at sym3 = FFT.
//     - 24 contiguous writes.
//     - Sym_Done at cycles 12 and 24; RE_Done with the 24th.
//  2. Comb1, N_sc=5: DMRS at addr 6,8,...,16; zeros at 5,7,...; Dmrs_Ready never high on zero REs.
//  3. Map bits 2 and 11, Sym 0..13: DMRS only in symbols 2 and 11, FFT elsewhere, 14 Sym_Done pulses.
//  4. Random valid gaps, 50% duty, on both streams:
//     - Output sequence identical to the no-stall run.
//     - No sample lost or duplicated.
//  5. Rejected configs, each setting Cfg_Err=1 with no writes:
//     - N_sc=1190, N_rb=1
//     - N_rb=0
//     - Sym_Start=5, Sym_End=4
//  6. RST_RE mid-symbol:
//     - Outputs 0 next cycle, no RE_Done.
//     - A new Start then runs a clean slot from k=0.
//  Bench also checks: DMRS_SHIFT=3 gives -1 -> -8.

Source files
------------

// File: rtl/re_map_pkg.sv
// re_map_pkg
//   Shared definitions for the PUSCH resource-element mapper:
//   grid limits, RE-per-RB constant, FSM state encoding and the
//   DMRS sign-extension/amplitude-alignment helper.
package re_map_pkg;

  localparam int NSC_TOT   = 1200;  // subcarriers in the grid
  localparam int NSYM      = 14;    // symbols per slot
  localparam int RE_PER_RB = 12;    // subcarriers per resource block
  localparam int SC_W      = 11;    // width of the per-symbol RE counter (12*127 fits)

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_MAP  = 1'b1
  } map_state_e;

  // Sign-extend the low src_w bits of raw to 32 bits, then shift left.
  // The caller truncates the result to its output width.
  function automatic logic [31:0] dmrs_ext(input logic [31:0] raw,
                                           input int          src_w,
                                           input int          shift);
    logic signed [31:0] tmp;
    tmp = $signed(raw << (32'sd32 - src_w));
    tmp = tmp >>> (32'sd32 - src_w);
    return tmp <<< shift;
  endfunction

endpackage

// File: rtl/re_cfg_check.sv
// re_cfg_check
//   Purely combinational validation of a slot configuration.
//   Ports:
//     n_sc      in  ADDR_W  first allocated subcarrier
//     n_rb      in  7       allocated RBs
//     sym_start in  4       first symbol
//     sym_end   in  4       last symbol
//     cfg_err   out 1       configuration is not mappable
//     sc_count  out SC_W    REs per symbol (12*n_rb)
module re_cfg_check
  import re_map_pkg::*;
#(
  parameter int ADDR_W  = 11,
  parameter int NSC_MAX = 1200,
  parameter int NSYM_MAX = 14
) (
  input  logic [ADDR_W-1:0] n_sc,
  input  logic [6:0]        n_rb,
  input  logic [3:0]        sym_start,
  input  logic [3:0]        sym_end,
  output logic              cfg_err,
  output logic [SC_W-1:0]   sc_count
);

  logic [11:0] span_end_s;
  logic        err_rb_s;
  logic        err_order_s;
  logic        err_symend_s;
  logic        err_span_s;

  // 12*n_rb as 8*n_rb + 4*n_rb to keep it a pair of shifted adds
  assign sc_count = SC_W'({n_rb, 3'b000}) + SC_W'({n_rb, 2'b00});

  // 12-bit sum cannot overflow: max 2047 + 1524
  assign span_end_s = 12'(n_sc) + 12'(sc_count);

  assign err_rb_s     = (n_rb == 7'd0);
  assign err_order_s  = (sym_start > sym_end);
  assign err_symend_s = ({1'b0, sym_end} >= 5'(NSYM_MAX));
  assign err_span_s   = (span_end_s > 12'(NSC_MAX));

  assign cfg_err = err_rb_s | err_order_s | err_symend_s | err_span_s;

endmodule

// File: rtl/re_mapper_multisym.sv
// re_mapper_multisym
//   PUSCH resource-element mapper for a slot span Sym_Start..Sym_End.
//   Symbols flagged in Dmrs_Sym_Map carry comb-2 DMRS (other REs zero);
//   all other symbols carry the transform-precoded data stream.
//   One RE per cycle, valid/ready on both inputs, registered outputs.
//   Ports:
//     CLK_RE, RST_RE          clock, synchronous active-high reset
//     Start                   pulse: latch config and begin the slot
//     N_sc, N_rb              first subcarrier, allocated RBs
//     Sym_Start, Sym_End      symbol span of the allocation
//     Dmrs_Sym_Map            bit s=1: symbol s is DMRS
//     Dmrs_Comb               DMRS on REs with k[0]==Dmrs_Comb
//     Dmrs_I/Q, Dmrs_Valid, Dmrs_Ready   DMRS sample stream
//     FFT_I/Q, FFT_Valid, FFT_Ready      data sample stream
//     RE_Real/Imj, RE_Valid_Out          grid write data and strobe
//     Wr_addr, Wr_sym                    grid address (N_sc+k) and symbol
//     Sym_Done, RE_Done                  last RE of symbol / slot
//     Busy, Cfg_Err                      slot in progress / config rejected
module re_mapper_multisym #(
  parameter int DATA_W     = 18,
  parameter int DMRS_W     = 9,
  parameter int DMRS_SHIFT = 0,
  parameter int ADDR_W     = 11,
  parameter int NSC_TOT    = re_map_pkg::NSC_TOT,
  parameter int NSYM       = re_map_pkg::NSYM
) (
  input  logic              CLK_RE,
  input  logic              RST_RE,
  input  logic              Start,
  input  logic [ADDR_W-1:0] N_sc,
  input  logic [6:0]        N_rb,
  input  logic [3:0]        Sym_Start,
  input  logic [3:0]        Sym_End,
  input  logic [NSYM-1:0]   Dmrs_Sym_Map,
  input  logic              Dmrs_Comb,
  input  logic [DMRS_W-1:0] Dmrs_I,
  input  logic [DMRS_W-1:0] Dmrs_Q,
  input  logic              Dmrs_Valid,
  output logic              Dmrs_Ready,
  input  logic [DATA_W-1:0] FFT_I,
  input  logic [DATA_W-1:0] FFT_Q,
  input  logic              FFT_Valid,
  output logic              FFT_Ready,
  output logic [DATA_W-1:0] RE_Real,
  output logic [DATA_W-1:0] RE_Imj,
  output logic              RE_Valid_Out,
  output logic [ADDR_W-1:0] Wr_addr,
  output logic [3:0]        Wr_sym,
  output logic              Sym_Done,
  output logic              RE_Done,
  output logic              Busy,
  output logic              Cfg_Err
);

  import re_map_pkg::*;

  // latched slot configuration
  map_state_e        state_r;
  logic [SC_W-1:0]   k_r;
  logic [3:0]        sym_r;
  logic [ADDR_W-1:0] n_sc_r;
  logic [SC_W-1:0]   sc_cnt_r;
  logic [3:0]        sym_end_r;
  logic [15:0]       map_r;
  logic              comb_r;

  // config checker outputs
  logic              cfg_err_s;
  logic [SC_W-1:0]   sc_count_s;

  // per-cycle mapping decisions
  logic              is_dmrs_sym_s;
  logic              dmrs_pos_s;
  logic              dmrs_rdy_s;
  logic              fft_rdy_s;
  logic              advance_s;
  logic              last_k_s;
  logic              last_sym_s;
  logic [DATA_W-1:0] dmrs_i_ext_s;
  logic [DATA_W-1:0] dmrs_q_ext_s;
  logic [DATA_W-1:0] re_i_s;
  logic [DATA_W-1:0] re_q_s;

  re_cfg_check #(
    .ADDR_W   (ADDR_W),
    .NSC_MAX  (NSC_TOT),
    .NSYM_MAX (NSYM)
  ) u_cfg_check (
    .n_sc      (N_sc),
    .n_rb      (N_rb),
    .sym_start (Sym_Start),
    .sym_end   (Sym_End),
    .cfg_err   (cfg_err_s),
    .sc_count  (sc_count_s)
  );

  assign dmrs_i_ext_s = DATA_W'(dmrs_ext(32'(Dmrs_I), DMRS_W, DMRS_SHIFT));
  assign dmrs_q_ext_s = DATA_W'(dmrs_ext(32'(Dmrs_Q), DMRS_W, DMRS_SHIFT));

  // map is held 16 wide so any 4-bit symbol index is in range
  assign is_dmrs_sym_s = map_r[sym_r];
  assign dmrs_pos_s    = (k_r[0] == comb_r);
  assign last_k_s      = (k_r == (sc_cnt_r - SC_W'(1)));
  assign last_sym_s    = (sym_r == sym_end_r);

  // readies are combinational so a sample is taken in the same cycle it is offered
  assign Dmrs_Ready = dmrs_rdy_s;
  assign FFT_Ready  = fft_rdy_s;

  // Decide which stream feeds the current RE and whether position k advances
  always_comb begin
    dmrs_rdy_s = 1'b0;
    fft_rdy_s  = 1'b0;
    advance_s  = 1'b0;
    re_i_s     = {DATA_W{1'b0}};
    re_q_s     = {DATA_W{1'b0}};
    if (state_r == ST_MAP) begin
      if (is_dmrs_sym_s) begin
        if (dmrs_pos_s) begin
          dmrs_rdy_s = 1'b1;
          advance_s  = Dmrs_Valid;
          re_i_s     = dmrs_i_ext_s;
          re_q_s     = dmrs_q_ext_s;
        end else begin
          // empty comb position: write 0+j0 without touching either stream
          advance_s  = 1'b1;
        end
      end else begin
        fft_rdy_s = 1'b1;
        advance_s = FFT_Valid;
        re_i_s    = FFT_I;
        re_q_s    = FFT_Q;
      end
    end else begin
      advance_s = 1'b0;
    end
  end

  // FSM, k/sym counters and output register stage
  always_ff @(posedge CLK_RE) begin
    if (RST_RE) begin
      state_r      <= ST_IDLE;
      k_r          <= {SC_W{1'b0}};
      sym_r        <= 4'd0;
      n_sc_r       <= {ADDR_W{1'b0}};
      sc_cnt_r     <= {SC_W{1'b0}};
      sym_end_r    <= 4'd0;
      map_r        <= 16'd0;
      comb_r       <= 1'b0;
      RE_Real      <= {DATA_W{1'b0}};
      RE_Imj       <= {DATA_W{1'b0}};
      RE_Valid_Out <= 1'b0;
      Wr_addr      <= {ADDR_W{1'b0}};
      Wr_sym       <= 4'd0;
      Sym_Done     <= 1'b0;
      RE_Done      <= 1'b0;
      Busy         <= 1'b0;
      Cfg_Err      <= 1'b0;
    end else begin
      RE_Valid_Out <= advance_s;
      Sym_Done     <= advance_s & last_k_s;
      RE_Done      <= advance_s & last_k_s & last_sym_s;
      if (advance_s) begin
        RE_Real <= re_i_s;
        RE_Imj  <= re_q_s;
        Wr_addr <= n_sc_r + ADDR_W'(k_r);
        Wr_sym  <= sym_r;
      end

      case (state_r)
        ST_IDLE: begin
          if (Start) begin
            n_sc_r    <= N_sc;
            sc_cnt_r  <= sc_count_s;
            sym_end_r <= Sym_End;
            map_r     <= 16'(Dmrs_Sym_Map);
            comb_r    <= Dmrs_Comb;
            Cfg_Err   <= cfg_err_s;
            if (!cfg_err_s) begin
              state_r <= ST_MAP;
              Busy    <= 1'b1;
              sym_r   <= Sym_Start;
              k_r     <= {SC_W{1'b0}};
            end
          end
        end
        ST_MAP: begin
          // Start is ignored here, so the latched config holds for the slot
          if (advance_s) begin
            if (last_k_s) begin
              k_r <= {SC_W{1'b0}};
              if (last_sym_s) begin
                state_r <= ST_IDLE;
                Busy    <= 1'b0;
              end else begin
                // next symbol starts in the very next cycle, no bubble
                sym_r <= sym_r + 4'd1;
              end
            end else begin
              k_r <= k_r + SC_W'(1);
            end
          end
        end
        default: begin
          state_r <= ST_IDLE;
          Busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_re_mapper_multisym.sv
// tb_re_mapper_multisym
//   Scoreboard bench: a reference model pushes the expected RE sequence of
//   a slot when Start is driven; a negedge monitor pops and compares every
//   grid write. Stream sources are deterministic functions of the sample
//   index, so stalled and unstalled runs must produce identical output.
module tb_re_mapper_multisym;

  localparam int DATA_W = 18;
  localparam int DMRS_W = 9;
  localparam int SHIFT  = 3;
  localparam int ADDR_W = 11;
  localparam int NSYM   = 14;

  logic              CLK_RE;
  logic              RST_RE;
  logic              Start;
  logic [ADDR_W-1:0] N_sc;
  logic [6:0]        N_rb;
  logic [3:0]        Sym_Start;
  logic [3:0]        Sym_End;
  logic [NSYM-1:0]   Dmrs_Sym_Map;
  logic              Dmrs_Comb;
  logic [DMRS_W-1:0] Dmrs_I;
  logic [DMRS_W-1:0] Dmrs_Q;
  logic              Dmrs_Valid;
  logic              Dmrs_Ready;
  logic [DATA_W-1:0] FFT_I;
  logic [DATA_W-1:0] FFT_Q;
  logic              FFT_Valid;
  logic              FFT_Ready;
  logic [DATA_W-1:0] RE_Real;
  logic [DATA_W-1:0] RE_Imj;
  logic              RE_Valid_Out;
  logic [ADDR_W-1:0] Wr_addr;
  logic [3:0]        Wr_sym;
  logic              Sym_Done;
  logic              RE_Done;
  logic              Busy;
  logic              Cfg_Err;

  re_mapper_multisym #(
    .DATA_W     (DATA_W),
    .DMRS_W     (DMRS_W),
    .DMRS_SHIFT (SHIFT),
    .ADDR_W     (ADDR_W),
    .NSC_TOT    (1200),
    .NSYM       (NSYM)
  ) dut (
    .CLK_RE       (CLK_RE),
    .RST_RE       (RST_RE),
    .Start        (Start),
    .N_sc         (N_sc),
    .N_rb         (N_rb),
    .Sym_Start    (Sym_Start),
    .Sym_End      (Sym_End),
    .Dmrs_Sym_Map (Dmrs_Sym_Map),
    .Dmrs_Comb    (Dmrs_Comb),
    .Dmrs_I       (Dmrs_I),
    .Dmrs_Q       (Dmrs_Q),
    .Dmrs_Valid   (Dmrs_Valid),
    .Dmrs_Ready   (Dmrs_Ready),
    .FFT_I        (FFT_I),
    .FFT_Q        (FFT_Q),
    .FFT_Valid    (FFT_Valid),
    .FFT_Ready    (FFT_Ready),
    .RE_Real      (RE_Real),
    .RE_Imj       (RE_Imj),
    .RE_Valid_Out (RE_Valid_Out),
    .Wr_addr      (Wr_addr),
    .Wr_sym       (Wr_sym),
    .Sym_Done     (Sym_Done),
    .RE_Done      (RE_Done),
    .Busy         (Busy),
    .Cfg_Err      (Cfg_Err)
  );

  initial CLK_RE = 1'b0;
  always #5 CLK_RE = ~CLK_RE;

  typedef struct {
    logic [DATA_W-1:0] re;
    logic [DATA_W-1:0] im;
    logic [ADDR_W-1:0] addr;
    logic [3:0]        sym;
    logic              sd;
    logic              rd;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int fft_idx = 0;
  int dmrs_idx = 0;
  logic stall_en = 1'b0;
  logic hold = 1'b0;

  int   wr_cnt = 0;
  int   sd_cnt = 0;
  int   rd_cnt = 0;
  int   first_cyc = 0;
  int   last_cyc = 0;
  int   start_cyc = 0;
  logic first_seen = 1'b0;
  logic [DATA_W-1:0] first_re = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [DMRS_W-1:0] dmrs_i_val(input int n);
    return DMRS_W'(n * 71 + 511);   // sample 0 is -1
  endfunction
  function automatic logic [DMRS_W-1:0] dmrs_q_val(input int n);
    return DMRS_W'(n * 53 + 100);
  endfunction
  function automatic logic [DATA_W-1:0] fft_i_val(input int n);
    return DATA_W'(n * 1031 + 7);
  endfunction
  function automatic logic [DATA_W-1:0] fft_q_val(input int n);
    return DATA_W'(n * 2477 + 200000);
  endfunction
  // signed DMRS value times 2**SHIFT (SHIFT = 3)
  function automatic logic [DATA_W-1:0] dmrs_exp(input logic [DMRS_W-1:0] d);
    logic signed [DATA_W-1:0] v;
    v = $signed(d);
    v = v * 18'sd8;
    return v;
  endfunction

  task automatic drive_streams();
    FFT_I      = fft_i_val(fft_idx);
    FFT_Q      = fft_q_val(fft_idx);
    Dmrs_I     = dmrs_i_val(dmrs_idx);
    Dmrs_Q     = dmrs_q_val(dmrs_idx);
    FFT_Valid  = hold ? 1'b0 : (stall_en ? 1'($urandom_range(0, 1)) : 1'b1);
    Dmrs_Valid = hold ? 1'b0 : (stall_en ? 1'($urandom_range(0, 1)) : 1'b1);
  endtask

  // one clock: note handshakes before the edge, advance sources after it
  task automatic step();
    logic ff;
    logic df;
    @(negedge CLK_RE);
    ff = FFT_Valid && FFT_Ready;
    df = Dmrs_Valid && Dmrs_Ready;
    @(posedge CLK_RE);
    #1;
    if (ff) fft_idx++;
    if (df) dmrs_idx++;
    drive_streams();
  endtask

  task automatic model_slot(input int nsc, input int nrb, input int s0, input int s1,
                            input logic [NSYM-1:0] map, input logic comb);
    int fi;
    int di;
    exp_t e;
    fi = fft_idx;
    di = dmrs_idx;
    for (int s = s0; s <= s1; s++) begin
      for (int k = 0; k < 12 * nrb; k++) begin
        e.addr = ADDR_W'(nsc + k);
        e.sym  = 4'(s);
        e.sd   = (k == 12 * nrb - 1);
        e.rd   = e.sd && (s == s1);
        if (map[s]) begin
          if (k[0] == comb) begin
            e.re = dmrs_exp(dmrs_i_val(di));
            e.im = dmrs_exp(dmrs_q_val(di));
            di++;
          end else begin
            e.re = '0;
            e.im = '0;
          end
        end else begin
          e.re = fft_i_val(fi);
          e.im = fft_q_val(fi);
          fi++;
        end
        sb_q.push_back(e);
      end
    end
  endtask

  task automatic clear_stats();
    wr_cnt = 0;
    sd_cnt = 0;
    first_seen = 1'b0;
  endtask

  task automatic start_slot(input int nsc, input int nrb, input int s0, input int s1,
                            input logic [NSYM-1:0] map, input logic comb, input logic good);
    N_sc         = ADDR_W'(nsc);
    N_rb         = 7'(nrb);
    Sym_Start    = 4'(s0);
    Sym_End      = 4'(s1);
    Dmrs_Sym_Map = map;
    Dmrs_Comb    = comb;
    Start        = 1'b1;
    if (good) model_slot(nsc, nrb, s0, s1, map, comb);
    step();
    Start     = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic wait_slot(input int budget);
    int d0;
    int n;
    d0 = rd_cnt;
    n  = 0;
    while (rd_cnt == d0 && n < budget) begin
      step();
      n++;
    end
    chk("slot_done", 64'(rd_cnt - d0), 64'd1);
    step();
    chk("sb_empty", 64'(sb_q.size()), 64'd0);
    chk("busy_idle", 64'(Busy), 64'd0);
  endtask

  always @(posedge CLK_RE) cyc <= cyc + 1;

  // output monitor: every grid write must match the next scoreboard entry
  always @(negedge CLK_RE) begin
    if (!RST_RE) begin
      chk("ready_excl", 64'(Dmrs_Ready & FFT_Ready), 64'd0);
      if (RE_Valid_Out) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_wr", 64'd1, 64'd0);
        end else begin
          mon_e = sb_q.pop_front();
          chk("re_real", 64'(RE_Real), 64'(mon_e.re));
          chk("re_imj",  64'(RE_Imj),  64'(mon_e.im));
          chk("wr_addr", 64'(Wr_addr), 64'(mon_e.addr));
          chk("wr_sym",  64'(Wr_sym),  64'(mon_e.sym));
          chk("sym_done", 64'(Sym_Done), 64'(mon_e.sd));
          chk("re_done",  64'(RE_Done),  64'(mon_e.rd));
        end
        if (!first_seen) begin
          first_seen = 1'b1;
          first_cyc  = cyc;
          first_re   = RE_Real;
        end
        last_cyc = cyc;
        wr_cnt++;
        if (Sym_Done) sd_cnt++;
        if (RE_Done) rd_cnt++;
      end else begin
        chk("done_no_wr", 64'({Sym_Done, RE_Done}), 64'd0);
      end
    end
  end

  initial begin
    int d0;
    int f0;
    int w0;
    int r0;
    RST_RE = 1'b1;
    Start = 1'b0;
    N_sc = '0;
    N_rb = '0;
    Sym_Start = '0;
    Sym_End = '0;
    Dmrs_Sym_Map = '0;
    Dmrs_Comb = 1'b0;
    drive_streams();
    repeat (3) step();
    chk("rst_valid", 64'(RE_Valid_Out), 64'd0);
    chk("rst_busy",  64'(Busy), 64'd0);
    chk("rst_err",   64'(Cfg_Err), 64'd0);
    chk("rst_addr",  64'(Wr_addr), 64'd0);
    chk("rst_real",  64'(RE_Real), 64'd0);
    RST_RE = 1'b0;
    step();

    // 1: one RB, symbol 2 DMRS comb0, symbol 3 data
    clear_stats();
    start_slot(0, 1, 2, 3, 14'b00_0000_0000_0100, 1'b0, 1'b1);
    chk("t1_busy", 64'(Busy), 64'd1);
    wait_slot(200);
    chk("t1_wr_cnt", 64'(wr_cnt), 64'd24);
    chk("t1_sd_cnt", 64'(sd_cnt), 64'd2);
    chk("t1_contig", 64'(last_cyc - first_cyc), 64'd23);
    chk("t1_latency", 64'(first_cyc - start_cyc), 64'd1);
    chk("shift_neg1", 64'(first_re), 64'h3FFF8);

    // 2: comb1 at N_sc=5, six DMRS samples consumed
    clear_stats();
    d0 = dmrs_idx;
    f0 = fft_idx;
    start_slot(5, 1, 4, 4, 14'b00_0000_0001_0000, 1'b1, 1'b1);
    wait_slot(200);
    chk("t2_dmrs_used", 64'(dmrs_idx - d0), 64'd6);
    chk("t2_fft_used", 64'(fft_idx - f0), 64'd0);
    chk("t2_wr_cnt", 64'(wr_cnt), 64'd12);

    // 3: DMRS in symbols 2 and 11, full slot
    clear_stats();
    start_slot(0, 2, 0, 13, 14'b00_1000_0000_0100, 1'b0, 1'b1);
    wait_slot(1000);
    chk("t3_sd_cnt", 64'(sd_cnt), 64'd14);
    chk("t3_wr_cnt", 64'(wr_cnt), 64'd336);

    // 4: same slot with 50% valid duty on both streams
    clear_stats();
    stall_en = 1'b1;
    d0 = dmrs_idx;
    f0 = fft_idx;
    start_slot(0, 2, 0, 13, 14'b00_1000_0000_0100, 1'b0, 1'b1);
    wait_slot(5000);
    stall_en = 1'b0;
    chk("t4_sd_cnt", 64'(sd_cnt), 64'd14);
    chk("t4_wr_cnt", 64'(wr_cnt), 64'd336);
    chk("t4_dmrs_used", 64'(dmrs_idx - d0), 64'd24);
    chk("t4_fft_used", 64'(fft_idx - f0), 64'd288);

    // 5: rejected configs
    for (int t = 0; t < 4; t++) begin
      w0 = wr_cnt;
      case (t)
        0: start_slot(1190, 1, 0, 0, 14'd0, 1'b0, 1'b0);
        1: start_slot(0, 0, 0, 0, 14'd0, 1'b0, 1'b0);
        2: start_slot(0, 1, 5, 4, 14'd0, 1'b0, 1'b0);
        default: start_slot(0, 1, 0, 14, 14'd0, 1'b0, 1'b0);
      endcase
      chk("t5_cfg_err", 64'(Cfg_Err), 64'd1);
      chk("t5_busy", 64'(Busy), 64'd0);
      repeat (20) step();
      chk("t5_no_wr", 64'(wr_cnt - w0), 64'd0);
    end

    // boundary: last RB ends exactly at the grid edge, clears Cfg_Err
    clear_stats();
    start_slot(1188, 1, 13, 13, 14'd0, 1'b0, 1'b1);
    chk("edge_err_clr", 64'(Cfg_Err), 64'd0);
    wait_slot(200);
    chk("edge_wr_cnt", 64'(wr_cnt), 64'd12);

    // 6: reset mid-symbol, then a clean slot
    clear_stats();
    start_slot(0, 2, 0, 1, 14'b00_0000_0000_0001, 1'b0, 1'b1);
    repeat (10) step();
    hold = 1'b1;
    drive_streams();
    RST_RE = 1'b1;
    r0 = rd_cnt;
    step();
    sb_q.delete();
    chk("t6_rst_valid", 64'(RE_Valid_Out), 64'd0);
    chk("t6_rst_busy",  64'(Busy), 64'd0);
    chk("t6_rst_done",  64'({Sym_Done, RE_Done}), 64'd0);
    chk("t6_rst_addr",  64'(Wr_addr), 64'd0);
    RST_RE = 1'b0;
    hold = 1'b0;
    repeat (5) step();
    chk("t6_no_re_done", 64'(rd_cnt - r0), 64'd0);
    clear_stats();
    start_slot(3, 1, 6, 6, 14'b00_0000_0100_0000, 1'b1, 1'b1);
    wait_slot(200);
    chk("t6_wr_cnt", 64'(wr_cnt), 64'd12);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
